pipeline_trace_buffer: RTL and testbench

//  Synthesizable retire-trace unit for mips_pipeline; replaces $display-only tracing in sim.

---
 rtl/pipeline_trace_buffer.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - retire-trace circular buffer with class counters and PC trigger
module pipeline_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int SEQ_W     = 16,
    parameter int CNT_W     = 16,
    parameter int POST_TRIG = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        mode_i,
    input  logic              clear_i,
    input  logic              cap_valid_i,
    input  logic [PC_W-1:0]   cap_pc_i,
    input  logic [31:0]       cap_instr_i,
    input  logic [DATA_W-1:0] cap_wd_i,
    input  logic [PC_W-1:0]   trig_pc_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [SEQ_W-1:0]  rd_seq_o,
    output logic [PC_W-1:0]   rd_pc_o,
    output logic [31:0]       rd_instr_o,
    output logic [DATA_W-1:0] rd_wd_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              triggered_o,
    input  logic [2:0]        cnt_sel_i,
    output logic [CNT_W-1:0]  cnt_out_o
);

    localparam logic [AW:0]      DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]      POST_LAST = (AW+1)'(POST_TRIG);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_e;

    // Each mode has a single state the FSM (re)starts from.
    function automatic state_e entry_of(input logic [1:0] m);
        case (m)
            2'b00:   return ST_IDLE;
            2'b11:   return ST_ARMED;
            default: return ST_RUN;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        mode_q;
    logic [AW:0]       post_cnt_q, post_cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              triggered_q, triggered_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [CNT_W-1:0]  cls_cnt_q [8];
    logic [CNT_W-1:0]  cnt_out_q;

    logic [SEQ_W-1:0]  seq_mem   [DEPTH];
    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [DATA_W-1:0] wd_mem    [DEPTH];

    logic              store_req;
    logic              trig_hit;
    logic              wr_en;
    logic              pop;
    logic              full_w;
    logic              rd_valid_w;
    logic              cnt_en;
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [2:0]        cls;

    assign op         = cap_instr_i[31:26];
    assign fn         = cap_instr_i[5:0];
    assign full_w     = (count_q == DEPTH_C);
    assign rd_valid_w = (count_q != '0);
    assign pop        = rd_valid_w && rd_ready_i && !clear_i;
    assign cnt_en     = cap_valid_i && (mode_i != 2'b00) && !clear_i;

    // Classify the retiring instruction; NOP takes priority over sll's zero funct.
    always_comb begin
        cls = 3'd7;
        if (cap_instr_i == 32'd0) begin
            cls = 3'd0;
        end else if (op == 6'd0 && (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 ||
                                    fn == 6'd37 || fn == 6'd0)) begin
            cls = 3'd1;
        end else if (op == 6'd0 && (fn == 6'd25 || fn == 6'd10 || fn == 6'd12)) begin
            cls = 3'd2;
        end else if (op == 6'd35 || op == 6'd43) begin
            cls = 3'd3;
        end else if (op == 6'd4) begin
            cls = 3'd4;
        end else if (op == 6'd2 || op == 6'd8) begin
            cls = 3'd5;
        end else if (op == 6'd12) begin
            cls = 3'd6;
        end
    end

    // Capture FSM next state: decides whether this cycle's retire is offered to the buffer.
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        store_req  = 1'b0;
        trig_hit   = 1'b0;
        if (mode_i != mode_q) begin
            state_d = entry_of(mode_i);
        end else begin
            case (state_q)
                ST_RUN: begin
                    store_req = cap_valid_i;
                end
                ST_ARMED: begin
                    if (cap_valid_i && cap_pc_i == trig_pc_i) begin
                        store_req  = 1'b1;
                        trig_hit   = 1'b1;
                        post_cnt_d = {{AW{1'b0}}, 1'b1};
                        state_d    = (POST_TRIG == 1) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (cap_valid_i) begin
                        store_req  = 1'b1;
                        post_cnt_d = post_cnt_q + 1'b1;
                        if (post_cnt_q + 1'b1 == POST_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (clear_i) begin
            state_d    = entry_of(mode_i);
            post_cnt_d = '0;
            store_req  = 1'b0;
            trig_hit   = 1'b0;
        end
    end

    // Buffer bookkeeping: pop is taken before push, so a full buffer with a pop accepts the push.
    always_comb begin
        wr_en       = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q || trig_hit;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        if (store_req) begin
            if (pop || !full_w) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = pop ? count_q : count_q + 1'b1;
            end else if (mode_i == 2'b01) begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                overflow_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (clear_i) begin
            wr_en       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_i;
            post_cnt_q  <= post_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
        end
    end

    // Sequence number and saturating per-class counters advance on every retire while enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q     <= '0;
            cnt_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cls_cnt_q[i] <= '0;
            end
        end else if (clear_i) begin
            seq_q     <= '0;
            cnt_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cls_cnt_q[i] <= '0;
            end
        end else begin
            cnt_out_q <= cls_cnt_q[cnt_sel_i];
            if (cnt_en) begin
                seq_q <= seq_q + 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (cnt_en && cls == 3'(i) && cls_cnt_q[i] != CNT_MAX) begin
                    cls_cnt_q[i] <= cls_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Record storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            seq_mem[wr_ptr_q]   <= seq_q;
            pc_mem[wr_ptr_q]    <= cap_pc_i;
            instr_mem[wr_ptr_q] <= cap_instr_i;
            wd_mem[wr_ptr_q]    <= cap_wd_i;
        end
    end

    assign rd_valid_o  = rd_valid_w;
    assign rd_seq_o    = rd_valid_w ? seq_mem[rd_ptr_q]   : '0;
    assign rd_pc_o     = rd_valid_w ? pc_mem[rd_ptr_q]    : '0;
    assign rd_instr_o  = rd_valid_w ? instr_mem[rd_ptr_q] : '0;
    assign rd_wd_o     = rd_valid_w ? wd_mem[rd_ptr_q]    : '0;
    assign count_o     = count_q;
    assign full_o      = full_w;
    assign overflow_o  = overflow_q;
    assign triggered_o = triggered_q;
    assign cnt_out_o   = cnt_out_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - self-checking bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int POST   = 8;
    localparam int CNTMAX = 15;

    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_ADD   = 32'h01094020;
    localparam logic [31:0] I_SLL   = 32'h00084080;
    localparam logic [31:0] I_MULTU = 32'h01090019;
    localparam logic [31:0] I_LW    = 32'h8D090000;
    localparam logic [31:0] I_SW    = 32'hAD090000;
    localparam logic [31:0] I_BEQ   = 32'h11090003;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_ANDI  = 32'h31090001;
    localparam logic [31:0] I_ORI   = 32'h35090001;
    localparam logic [31:0] I_MOVZ  = 32'h0109400A;
    localparam logic [31:0] I_SYSC  = 32'h0000000C;
    localparam logic [31:0] I_ADDI  = 32'h21090001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        clear = 1'b0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [31:0] cap_instr = '0;
    logic [31:0] cap_wd = '0;
    logic [31:0] trig_pc = '0;
    logic        rd_ready = 1'b0;
    logic [2:0]  cnt_sel = '0;
    logic        rd_valid;
    logic [15:0] rd_seq;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] rd_wd;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        triggered;
    logic [3:0]  cnt_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
    } rec_t;

    rec_t q[$];
    int   m_seq;
    int   m_cnt [8];
    int   m_ovf;
    int   m_trig;
    bit   m_hit;
    int   m_after;

    pipeline_trace_buffer #(
        .DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .SEQ_W(16), .CNT_W(4), .POST_TRIG(POST)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .clear_i(clear),
        .cap_valid_i(cap_valid), .cap_pc_i(cap_pc), .cap_instr_i(cap_instr), .cap_wd_i(cap_wd),
        .trig_pc_i(trig_pc), .rd_ready_i(rd_ready), .rd_valid_o(rd_valid), .rd_seq_o(rd_seq),
        .rd_pc_o(rd_pc), .rd_instr_o(rd_instr), .rd_wd_o(rd_wd), .count_o(count), .full_o(full),
        .overflow_o(overflow), .triggered_o(triggered), .cnt_sel_i(cnt_sel), .cnt_out_o(cnt_out)
    );

    always #5 clk = ~clk;

    function automatic int klass(input logic [31:0] ins);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (ins == 32'd0) return 0;
        if (op == 0) begin
            if (fn inside {32, 34, 36, 37, 0}) return 1;
            if (fn inside {25, 10, 12}) return 2;
            return 7;
        end
        if (op inside {35, 43}) return 3;
        if (op == 4) return 4;
        if (op inside {2, 8}) return 5;
        if (op == 12) return 6;
        return 7;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_seq = 0;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_ovf   = 0;
        m_trig  = 0;
        m_hit   = 1'b0;
        m_after = 0;
    endtask

    task automatic chk_status(input string tag);
        check({tag, "_count"}, 64'(count), 64'(q.size()));
        check({tag, "_full"}, 64'(full), 64'(q.size() == DEPTH));
        check({tag, "_rdvalid"}, 64'(rd_valid), 64'(q.size() != 0));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_trig"}, 64'(triggered), 64'(m_trig));
    endtask

    task automatic chk_cnt(input string tag);
        for (int k = 0; k < 8; k++) begin
            cnt_sel = 3'(k);
            @(posedge clk); #1;
            check($sformatf("%s_cnt%0d", tag, k), 64'(cnt_out), 64'(m_cnt[k]));
        end
    endtask

    // One clock: drive a retire and/or pop, advance the reference model by the same step.
    task automatic cyc(input bit cv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] wd, input bit rdy);
        rec_t r;
        bit   store;
        int   k;
        cap_valid = cv;
        cap_pc    = pc;
        cap_instr = ins;
        cap_wd    = wd;
        rd_ready  = rdy;
        if (rdy && q.size() > 0) begin
            check("head_seq", 64'(rd_seq), 64'(q[0].seq));
            check("head_pc", 64'(rd_pc), 64'(q[0].pc));
            check("head_instr", 64'(rd_instr), 64'(q[0].instr));
            check("head_wd", 64'(rd_wd), 64'(q[0].wd));
        end
        r.seq   = 16'(m_seq);
        r.pc    = pc;
        r.instr = ins;
        r.wd    = wd;
        store   = 1'b0;
        if (cv && mode != 2'b00) begin
            k = klass(ins);
            if (m_cnt[k] < CNTMAX) m_cnt[k]++;
            m_seq = (m_seq + 1) % 65536;
        end
        if (mode == 2'b01 || mode == 2'b10) begin
            store = cv;
        end else if (mode == 2'b11 && cv) begin
            if (m_hit) begin
                if (m_after < POST) begin
                    store = 1'b1;
                    m_after++;
                end
            end else if (pc == trig_pc) begin
                store   = 1'b1;
                m_hit   = 1'b1;
                m_trig  = 1;
                m_after = 1;
            end
        end
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (store) begin
            if (q.size() < DEPTH) begin
                q.push_back(r);
            end else if (mode == 2'b01) begin
                void'(q.pop_front());
                q.push_back(r);
                m_ovf = 1;
            end else begin
                m_ovf = 1;
            end
        end
        @(posedge clk); #1;
        cap_valid = 1'b0;
        rd_ready  = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (m != mode) begin
            m_hit   = 1'b0;
            m_after = 0;
        end
        mode = m;
        @(posedge clk); #1;
    endtask

    task automatic do_clear(input bit cv);
        clear     = 1'b1;
        cap_valid = cv;
        cap_pc    = trig_pc;
        cap_instr = I_LW;
        cap_wd    = 32'hDEAD_BEEF;
        rd_ready  = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
        cap_valid = 1'b0;
        rd_ready  = 1'b0;
        model_clear();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk_status("rst");
        check("rst_cnt_out", 64'(cnt_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] t4_ins [9];
        int          t4_exp [8];
        model_clear();

        // Reset state
        #12;
        chk_status("por");
        check("por_cnt_out", 64'(cnt_out), 64'd0);
        check("por_rd_pc", 64'(rd_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: wrap mode keeps the newest 16 of 20
        set_mode(2'b01);
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'(4 * i), I_ADD, 32'(i), 1'b0);
        chk_status("t1");
        check("t1_count", 64'(count), 64'd16);
        check("t1_ovf", 64'(overflow), 64'd1);
        check("t1_seq", 64'(rd_seq), 64'd4);
        check("t1_pc", 64'(rd_pc), 64'd16);
        cyc(1'b0, 0, 0, 0, 1'b1);

        // T2: stop-full drops the 17th; simultaneous push/pop when full keeps count
        set_mode(2'b10);
        do_clear(1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 32'(4 * i), I_ADD, $urandom, 1'b0);
        check("t2_full", 64'(full), 64'd1);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_seq", 64'(rd_seq), 64'd0);
        cyc(1'b1, 32'h100, I_SW, 32'h55, 1'b1);
        check("t2_count_pp", 64'(count), 64'd16);
        chk_status("t2a");
        do_clear(1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(4 * i), I_LW, $urandom, 1'b0);
        cyc(1'b1, 32'h200, I_SW, 32'h77, 1'b1);
        check("t2_count_pp2", 64'(count), 64'd16);
        check("t2_no_ovf", 64'(overflow), 64'd0);
        chk_status("t2b");

        // T3: trigger at 0x20 keeps 8 records 0x20..0x3C
        trig_pc = 32'h20;
        set_mode(2'b11);
        do_clear(1'b0);
        for (int i = 0; i <= 24; i++) cyc(1'b1, 32'(4 * i), I_ADD, 32'(i), 1'b0);
        check("t3_trig", 64'(triggered), 64'd1);
        check("t3_count", 64'(count), 64'd8);
        cyc(1'b1, 32'h20, I_ADD, 32'h1, 1'b0);
        check("t3_done", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_pc%0d", i), 64'(rd_pc), 64'(32'h20 + 4 * i));
            cyc(1'b0, 0, 0, 0, 1'b1);
        end
        chk_status("t3");

        // T4: one retire of each class, two memory ops
        set_mode(2'b01);
        do_clear(1'b0);
        t4_ins = '{I_NOP, I_SLL, I_MULTU, I_LW, I_SW, I_BEQ, I_J, I_ANDI, I_ORI};
        t4_exp = '{1, 1, 1, 2, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'(4 * i), t4_ins[i], 32'(i), 1'b0);
        for (int k = 0; k < 8; k++) begin
            cnt_sel = 3'(k);
            @(posedge clk); #1;
            check($sformatf("t4_cnt%0d", k), 64'(cnt_out), 64'(t4_exp[k]));
        end

        // T5: counter saturation at 15
        do_clear(1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'(4 * i), I_LW, 32'(i), 1'b0);
        cnt_sel = 3'd3;
        @(posedge clk); #1;
        check("t5_sat", 64'(cnt_out), 64'd15);
        chk_cnt("t5");

        // T6: clear with a concurrent retire, then reset mid-POST
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(4 * i), I_ADD, 32'(i), 1'b0);
        do_clear(1'b1);
        chk_status("t6c");
        check("t6_clr_count", 64'(count), 64'd0);
        chk_cnt("t6c");
        cyc(1'b1, 32'h44, I_ADD, 32'h9, 1'b0);
        check("t6_seq0", 64'(rd_seq), 64'd0);
        trig_pc = 32'h100;
        set_mode(2'b11);
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(4 * i), I_ADD, 32'(i), 1'b0);
        check("t6_post_count", 64'(count), 64'd4);
        do_reset();
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_trig", 64'(triggered), 64'd0);
        cyc(1'b1, 32'h100, I_ADD, 32'h3, 1'b0);
        check("t6_rst_seq0", 64'(rd_seq), 64'd0);
        chk_status("t6r");

        // Randomized traffic per mode against the reference model
        for (int m = 1; m <= 3; m++) begin
            logic [31:0] tbl [13];
            tbl = '{I_NOP, I_ADD, I_SLL, I_MULTU, I_LW, I_SW, I_BEQ, I_J, I_ANDI, I_ORI,
                    I_MOVZ, I_SYSC, I_ADDI};
            set_mode(2'(m));
            trig_pc = 32'h20;
            do_clear(1'b0);
            for (int i = 0; i < 150; i++) begin
                int sel;
                logic [31:0] ins;
                sel = int'($urandom_range(0, 13));
                ins = (sel == 13) ? $urandom : tbl[sel];
                cyc(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), ins, $urandom,
                    ($urandom_range(0, 99) < 40));
                chk_status($sformatf("rnd_m%0d", m));
            end
            chk_cnt($sformatf("rnd_m%0d", m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
